// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the dispatch controller: exception FSM states, performance
// counter bundle and the default dispatch width.
package dispatch_ctrl_pkg;

  localparam int DISPATCH_WIDTH = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [31:0] stall_rob;
    logic [31:0] stall_rs;
    logic [31:0] stall_rename;
    logic [31:0] stall_exc;
  } perf_cnt_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Credit counter: consumes i_dec, returns i_inc per cycle, restore reloads MAX.
// Returning more than MAX worth of credit is illegal; the count clamps at MAX.
module credit_counter #(
  parameter int MAX = 32,
  parameter int DW  = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_dec,
  input  logic [DW-1:0] i_inc,
  input  logic          i_restore,
  output logic [W-1:0]  o_credit
);

  logic [W-1:0] r_credit;
  logic [W:0]   w_sum;

  // spare top bit lets the overflow compare see values above MAX
  always_comb w_sum = {1'b0, r_credit} - (W+1)'(i_dec) + (W+1)'(i_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_credit <= W'(MAX);
    else if (i_restore)             r_credit <= W'(MAX);
    else if (w_sum > (W+1)'(MAX))   r_credit <= W'(MAX);
    else                            r_credit <= w_sum[W-1:0];
  end

  assign o_credit = r_credit;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !i_restore |-> (w_sum <= (W+1)'(MAX)));

endmodule

// File: rtl/dispatch_ctrl.sv
// N-wide in-order prefix dispatch gated by ROB/RS credits, plus exception stall FSM.
// Optional stall-cause counters on o_perf_cnt when DISPATCH_CTRL_PERF_EN is defined.
//   state | meaning
//   RUN   | normal dispatch
//   FLUSH | one cycle after exc_flush; credits restored to full
//   HOLD  | waiting for resume; nothing dispatches
module dispatch_ctrl import dispatch_ctrl_pkg::*; #(
  parameter int WIDTH     = DISPATCH_WIDTH,
  parameter int N_RS      = 2,
  parameter int ROB_DEPTH = 32,
  parameter int RS_DEPTH  = 8,
  parameter int CW        = $clog2(WIDTH + 1),
  parameter int SW        = (N_RS > 1) ? $clog2(N_RS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         i_uop_valid,
  input  logic [WIDTH-1:0][SW-1:0] i_uop_rs_sel,
  input  logic                     i_rename_stall,
  input  logic [CW-1:0]            i_rob_release,
  input  logic [N_RS-1:0]          i_rs_issue,
  input  logic                     i_exc_flush,
  input  logic                     i_resume,
  output logic [WIDTH-1:0]         o_dispatch_valid,
  output logic [CW-1:0]            o_dispatch_cnt,
  output logic                     o_stall,
  output logic                     o_proc_exception,
  output logic [1:0]               o_exc_state
`ifdef DISPATCH_CTRL_PERF_EN
  ,
  output perf_cnt_t                o_perf_cnt
`endif
);

  localparam int ROBW = $clog2(ROB_DEPTH + 1);
  localparam int RSW  = $clog2(RS_DEPTH + 1);

  exc_state_e                r_state;
  logic [ROBW-1:0]           w_rob_credit;
  logic [N_RS-1:0][RSW-1:0]  w_rs_credit;
  logic [N_RS-1:0][CW-1:0]   w_rs_take;
  logic [WIDTH-1:0]          w_dv;
  logic [CW-1:0]             w_cnt;
  logic                      w_go;
  logic                      w_open;

  assign w_go = rst_n && (r_state == RUN) && !i_rename_stall && !i_exc_flush;

  // the first slot that fails closes the window for every younger slot
  always_comb begin
    w_open    = w_go;
    w_dv      = '0;
    w_cnt     = '0;
    w_rs_take = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_open) begin
        if (!i_uop_valid[i]) begin
          w_open = 1'b0;
        end else if (int'(w_rob_credit) < i + 1) begin
          w_open = 1'b0;
        end else if ((int'(i_uop_rs_sel[i]) >= N_RS) ||
                     (int'(w_rs_credit[i_uop_rs_sel[i]]) <= int'(w_rs_take[i_uop_rs_sel[i]]))) begin
          w_open = 1'b0;
        end else begin
          w_dv[i] = 1'b1;
          w_cnt   = w_cnt + CW'(1);
          w_rs_take[i_uop_rs_sel[i]] = w_rs_take[i_uop_rs_sel[i]] + CW'(1);
        end
      end
    end
  end

  assign o_dispatch_valid = w_dv;
  assign o_dispatch_cnt   = w_cnt;
  assign o_stall          = !rst_n || (r_state != RUN) || i_rename_stall || (w_dv != i_uop_valid);
  assign o_proc_exception = i_exc_flush;
  assign o_exc_state      = r_state;

  credit_counter #(.MAX(ROB_DEPTH), .DW(CW), .W(ROBW)) u_rob_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_dec     (w_cnt),
    .i_inc     (i_rob_release),
    .i_restore (i_exc_flush),
    .o_credit  (w_rob_credit)
  );

  for (genvar k = 0; k < N_RS; k++) begin : g_rs_credit
    credit_counter #(.MAX(RS_DEPTH), .DW(CW), .W(RSW)) u_rs_credit (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_dec     (w_rs_take[k]),
      .i_inc     (CW'(i_rs_issue[k])),
      .i_restore (i_exc_flush),
      .o_credit  (w_rs_credit[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else if (i_exc_flush) begin
      r_state <= FLUSH;
    end else begin
      case (r_state)
        RUN:     r_state <= RUN;
        FLUSH:   r_state <= HOLD;
        HOLD:    if (i_resume) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef DISPATCH_CTRL_PERF_EN
  perf_cnt_t r_perf;
  logic      w_blk_slot;

  // dispatch is a prefix, so the blocking slot (if any) is index w_cnt
  always_comb w_blk_slot = (int'(w_cnt) < WIDTH) && i_uop_valid[w_cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if ((r_state != RUN) || i_exc_flush) begin
      r_perf.stall_exc <= sat_inc32(r_perf.stall_exc);
    end else if (i_rename_stall) begin
      r_perf.stall_rename <= sat_inc32(r_perf.stall_rename);
    end else if (w_blk_slot && (int'(w_rob_credit) < int'(w_cnt) + 1)) begin
      r_perf.stall_rob <= sat_inc32(r_perf.stall_rob);
    end else if (w_blk_slot) begin
      r_perf.stall_rs <= sat_inc32(r_perf.stall_rs);
    end
  end

  assign o_perf_cnt = r_perf;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl (WIDTH=4): stimulus pushes expected outputs
// from a credit/queue model, a negedge monitor pops and compares.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int W    = 4;
  localparam int NRS  = 2;
  localparam int ROBD = 32;
  localparam int RSD  = 8;
  localparam int CW   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W-1:0]      uv = '0;
  logic [W-1:0][0:0] sel = '0;
  logic              ren = 1'b0;
  logic [CW-1:0]     rel = '0;
  logic [NRS-1:0]    iss = '0;
  logic              flush = 1'b0;
  logic              resume = 1'b0;
  logic [W-1:0]      dv;
  logic [CW-1:0]     cnt;
  logic              stall;
  logic              pexc;
  logic [1:0]        st;

  always #5 clk = ~clk;

  dispatch_ctrl #(.WIDTH(W), .N_RS(NRS), .ROB_DEPTH(ROBD), .RS_DEPTH(RSD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_uop_valid      (uv),
    .i_uop_rs_sel     (sel),
    .i_rename_stall   (ren),
    .i_rob_release    (rel),
    .i_rs_issue       (iss),
    .i_exc_flush      (flush),
    .i_resume         (resume),
    .o_dispatch_valid (dv),
    .o_dispatch_cnt   (cnt),
    .o_stall          (stall),
    .o_proc_exception (pexc),
    .o_exc_state      (st)
  );

  typedef struct {
    logic [W-1:0] dv;
    int           cnt;
    bit           stall;
    bit           pexc;
    int           st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // model state: free ROB entries, free RS entries, mode 0=run 1=flush 2=hold
  int m_rob = ROBD;
  int m_rs[NRS] = '{RSD, RSD};
  int m_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dispatch_valid", 32'(dv), 32'(e.dv));
        chk("dispatch_cnt", 32'(cnt), e.cnt);
        chk("stall", 32'(stall), 32'(e.stall));
        chk("proc_exception", 32'(pexc), 32'(e.pexc));
        chk("exc_state", 32'(st), e.st);
      end
    end
  end

  task automatic cyc(input bit r, input logic [W-1:0] v, input logic [W-1:0] s, input bit rn,
                     input int rel_req, input logic [NRS-1:0] iss_req, input bit fl, input bit rsm);
    exp_t e;
    int   used[NRS];
    int   n;
    int   rel_amt;
    bit   open;
    @(posedge clk);
    #1;
    rst_n = r; uv = v; ren = rn; flush = fl; resume = rsm;
    for (int i = 0; i < W; i++) sel[i] = s[i];
    if (!r) begin
      m_rob = ROBD; m_rs = '{RSD, RSD}; m_mode = 0;
    end
    e.dv = '0; n = 0; used = '{0, 0};
    open = r && (m_mode == 0) && !rn && !fl;
    for (int i = 0; i < W; i++) begin
      if (open && v[i] && (m_rob >= i + 1) && (m_rs[s[i]] > used[s[i]])) begin
        e.dv[i] = 1'b1; n++; used[s[i]]++;
      end else begin
        open = 1'b0;
      end
    end
    e.cnt = n;
    e.stall = !r || (m_mode != 0) || rn || (e.dv != v);
    e.pexc = fl;
    e.st = m_mode;
    // releases are clamped to what can legally come back, except on a flush cycle
    rel_amt = (rel_req > 7) ? 7 : rel_req;
    if (!fl && (rel_amt > ROBD - (m_rob - n))) rel_amt = ROBD - (m_rob - n);
    rel = CW'(rel_amt);
    for (int k = 0; k < NRS; k++)
      iss[k] = iss_req[k] && (fl || (m_rs[k] - used[k] < RSD));
    q.push_back(e);
    if (r) begin
      if (fl) begin
        m_mode = 1; m_rob = ROBD; m_rs = '{RSD, RSD};
      end else begin
        m_rob = m_rob - n + rel_amt;
        for (int k = 0; k < NRS; k++) m_rs[k] = m_rs[k] - used[k] + int'(iss[k]);
        if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2 && rsm) m_mode = 0;
      end
    end
  endtask

  initial begin
    bit           r_b, low, rn_b, fl_b, rs_b;
    int           rr;
    logic [W-1:0] v_r, s_r;
    logic [1:0]   i_r;

    cyc(0, 4'b0011, 4'b0000, 0, 0, 2'b00, 0, 0);
    #2; chk("rst_dv", 32'(dv), 0); chk("rst_stall", 32'(stall), 1);
    cyc(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 1, 0);
    #2; chk("rst_pexc", 32'(pexc), 1);

    cyc(1, 4'b0011, 4'b0010, 0, 0, 2'b00, 0, 0);
    #2; chk("t1_dv", 32'(dv), 32'h3); chk("t1_cnt", 32'(cnt), 2); chk("t1_stall", 32'(stall), 0);
    cyc(1, 4'b1011, 4'b0000, 0, 0, 2'b00, 0, 0);
    #2; chk("gap_dv", 32'(dv), 32'h3); chk("gap_stall", 32'(stall), 1);
    cyc(1, 4'b1011, 4'b0000, 1, 0, 2'b00, 0, 0);
    #2; chk("rename_dv", 32'(dv), 0); chk("rename_stall", 32'(stall), 1);

    cyc(1, 4'b0011, 4'b0010, 0, 0, 2'b00, 1, 0);
    #2; chk("flush_pexc", 32'(pexc), 1); chk("flush_dv", 32'(dv), 0);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1);
    #2; chk("flush_state", 32'(st), 1); chk("flush_stall", 32'(stall), 1);
    cyc(1, 4'b1111, 4'b0000, 0, 0, 2'b00, 0, 0);
    #2; chk("hold_state", 32'(st), 2); chk("hold_dv", 32'(dv), 0);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 2'b00, 1, 1);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 2'b00, 0, 0);
    #2; chk("flush_wins_state", 32'(st), 1); chk("flush_wins_stall", 32'(stall), 1);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 0);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 2'b00, 0, 1);
    #2; chk("resume_cycle_stall", 32'(stall), 1);
    cyc(1, 4'b0011, 4'b0010, 0, 0, 2'b00, 0, 0);
    #2; chk("resumed_state", 32'(st), 0); chk("resumed_dv", 32'(dv), 32'h3);

    for (int i = 0; i < 6; i++) cyc(1, 4'b0001, 4'b0000, 0, 0, 2'b00, 0, 0);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 2'b01, 0, 0);
    #2; chk("rs_same_dv", 32'(dv), 32'h1); chk("rs_same_stall", 32'(stall), 1);
    cyc(1, 4'b0011, 4'b0010, 0, 0, 2'b11, 0, 0);
    #2; chk("rs_split_dv", 32'(dv), 32'h3);

    for (int g = 0; g < 40 && m_rob > 2; g++) cyc(1, 4'b0011, 4'b0010, 0, 0, 2'b11, 0, 0);
    if (m_rob == 2) cyc(1, 4'b0001, 4'b0000, 0, 0, 2'b01, 0, 0);
    cyc(1, 4'b0011, 4'b0010, 0, 2, 2'b01, 0, 0);
    #2; chk("rob1_dv", 32'(dv), 32'h1); chk("rob1_stall", 32'(stall), 1);
    cyc(1, 4'b0011, 4'b0010, 0, 0, 2'b01, 0, 0);
    #2; chk("rob_refill_dv", 32'(dv), 32'h3);

    for (int c = 0; c < 2400; c++) begin
      r_b  = ($urandom_range(0, 299) != 0);
      low  = ((c / 150) % 2) == 0;
      rr   = low ? (($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0) : $urandom_range(0, 7);
      i_r  = low ? (($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00) : 2'($urandom);
      v_r  = W'($urandom);
      s_r  = W'($urandom);
      rn_b = ($urandom_range(0, 9) == 0);
      fl_b = ($urandom_range(0, 79) == 0);
      rs_b = ($urandom_range(0, 3) == 0);
      cyc(r_b, v_r, s_r, rn_b, rr, i_r, fl_b, rs_b);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
